// File: rtl/mod47_pkg.sv
// Shared definitions for the sequential mod-47 multiplier: modulus, width,
// controller state encoding and the single-subtract reduction helper.
package mod47_pkg;

    localparam int MOD = 47;
    localparam int W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One conditional subtract of the modulus; callers guarantee x < 2*MOD,
    // so a single subtract always lands in 0..MOD-1.
    function automatic logic [W-1:0] reduce_once(input logic [W:0] x);
        return (x >= (W+1)'(MOD)) ? W'(x - (W+1)'(MOD)) : W'(x);
    endfunction

endpackage

// File: rtl/mod47_step.sv
// One MSB-first Horner step of modular multiplication:
// acc_o = ((2*acc_i mod 47) + (bit_i ? ap_i : 0)) mod 47.
// All intermediates fit in 7 bits (worst case 46+46 = 92).
module mod47_step (
    input  logic [5:0] acc_i,
    input  logic [5:0] ap_i,
    input  logic       bit_i,
    output logic [5:0] acc_o
);
    import mod47_pkg::*;

    logic [W-1:0] dblRed;
    logic [W:0]   sum;

    // Double, reduce, conditionally add the multiplicand, reduce again.
    always_comb begin
        dblRed = reduce_once({acc_i, 1'b0});
        sum    = {1'b0, dblRed} + (bit_i ? {1'b0, ap_i} : {(W+1){1'b0}});
        acc_o  = reduce_once(sum);
    end

endmodule

// File: rtl/mod47_mul_seq.sv
// Sequential (a*b) mod 47 multiplier with valid/ready handshakes on both
// sides. Six Horner steps per operation, one per clock.
// Optional build macro: MOD47_ERR_EN adds an 'err' output flagging that an
// operand was >= 47 when it was accepted.
module mod47_mul_seq #(
    parameter int MOD = 47,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r
`ifdef MOD47_ERR_EN
    ,
    output logic         err
`endif
);
    import mod47_pkg::*;

    state_t       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] acc_q;
    logic [2:0]   cnt_q;
    logic [W-1:0] r_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] aRed;
    logic [W-1:0] bRed;
    logic         accept;

    // Operands are folded into range once at accept time.
    always_comb begin
        aRed   = (a >= W'(MOD)) ? a - W'(MOD) : a;
        bRed   = (b >= W'(MOD)) ? b - W'(MOD) : b;
        accept = in_valid && in_ready_q;
    end

    mod47_step u_step (
        .acc_i (acc_q),
        .ap_i  (a_q),
        .bit_i (b_q[cnt_q]),
        .acc_o (acc_d)
    );

`ifdef MOD47_ERR_EN
    logic err_q;

    // Error flag captured at accept, held through DONE, cleared leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            err_q <= (a >= W'(MOD)) || (b >= W'(MOD));
        end else if (state_q == DONE && out_ready) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`endif

    // Controller: accept in IDLE, six Horner steps in BUSY, hold result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q        <= aRed;
                        b_q        <= bRed;
                        acc_q      <= '0;
                        cnt_q      <= 3'd5;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        r_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign r         = r_q;

endmodule

// File: tb/tb_mod47_mul_seq.sv
// Self-checking bench for mod47_mul_seq: directed corner operands plus
// randomized pairs, compared against plain (a*b) % 47 arithmetic.
// Build with MOD47_ERR_EN defined to also check the err output.
module tb_mod47_mul_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [5:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] r;
`ifdef MOD47_ERR_EN
    logic       err;
`endif

    int checkCount = 0;
    int failCount  = 0;

    mod47_mul_seq #(.MOD(47), .W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
`ifdef MOD47_ERR_EN
        ,
        .err       (err)
`endif
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation: accept, latency, DONE hold with ignored inputs, release.
    task automatic applyStimulus(input int av, input int bv, input int holdCycles);
        int expR;
        int waitCnt;
        int heldR;
        expR = (av * bv) % 47;
        waitCnt = 0;
        while (in_ready !== 1'b1 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput("ready_before_accept", int'(in_ready), 1);
        a        = 6'(av);
        b        = 6'(bv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 6'($urandom_range(0, 63));
        b        = 6'($urandom_range(0, 63));
        checkOutput("busy_in_ready", int'(in_ready), 0);
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick();
            checkOutput($sformatf("busy_no_valid_edge%0d", i), int'(out_valid), 0);
        end
        in_valid = 1'b0;
        tick();
        checkOutput("valid_at_edge6", int'(out_valid), 1);
        checkOutput($sformatf("r_%0dx%0d", av, bv), int'(r), expR);
        checkOutput("r_in_range", int'(r < 6'd47), 1);
`ifdef MOD47_ERR_EN
        checkOutput("err_flag", int'(err), ((av >= 47) || (bv >= 47)) ? 1 : 0);
`endif
        heldR = int'(r);
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 6'($urandom_range(0, 63));
            b        = 6'($urandom_range(0, 63));
            tick();
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_r", int'(r), heldR);
            checkOutput("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("release_valid_low", int'(out_valid), 0);
        checkOutput("release_idle_ready", int'(in_ready), 1);
`ifdef MOD47_ERR_EN
        checkOutput("release_err_clear", int'(err), 0);
`endif
    endtask

    initial begin
        int ra;
        int rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_r", int'(r), 0);
`ifdef MOD47_ERR_EN
        checkOutput("reset_err", int'(err), 0);
`endif

        applyStimulus(5, 7, 0);
        applyStimulus(46, 46, 1);
        applyStimulus(13, 29, 0);
        applyStimulus(0, 46, 0);
        applyStimulus(46, 0, 0);
        applyStimulus(50, 2, 2);
        applyStimulus(3, 2, 0);
        applyStimulus(63, 63, 10);

        // Abort mid-operation: reset lands on the third BUSY cycle.
        a        = 6'd9;
        b        = 6'd11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_r", int'(r), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("abort_no_result", int'(out_valid), 0);
        end
        applyStimulus(5, 7, 0);

        for (int n = 0; n < 20; n++) begin
            ra = int'($urandom_range(0, 63));
            rb = int'($urandom_range(0, 63));
            applyStimulus(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mod47_mul_seq.md
MOD47_MUL_SEQ -- requirements
Module: mod47_mul_seq

Interface
REQ-001 SHALL have parameter MOD, default 47, the modulus; the only value supported is 47.
REQ-002 SHALL have parameter W, default 6, the operand and result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, W bits: multiplicand residue.
REQ-008 SHALL have port b, input, W bits: multiplier residue.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port r, output, W bits: (a*b) mod 47.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-013 SHALL, on an edge with in_valid and in_ready high (accept), register a' = a-47 if a>=47 else a, and likewise b'; clear acc to 0; set cnt=5; and go to BUSY.
REQ-014 SHALL, in BUSY, perform one MSB-first Horner step per cycle: t = 2*acc reduced by one subtract of 47 if t>=47; then t = t + (b'[cnt] ? a' : 0), again reduced by one subtract of 47 if t>=47; then acc <= t.
REQ-015 SHALL use 7-bit intermediates; no intermediate exceeds 92.
REQ-016 SHALL decrement cnt each BUSY cycle and, on the step with cnt=0, go to DONE with r <= final acc.
REQ-017 SHALL make latency exactly 6 rising edges from the accept edge to out_valid=1, independent of operand values (including 0).
REQ-018 SHALL, in DONE, hold r and out_valid stable while out_ready=0.
REQ-019 SHALL return to IDLE on an edge with out_ready=1, with out_valid=0 from the next cycle.
REQ-020 SHALL NOT accept a new operand pair in DONE, even if in_valid=1 and out_ready=1 on the same edge; the next accept is possible no earlier than the following IDLE cycle.
REQ-021 SHALL ignore in_valid, a and b while in BUSY or DONE.
REQ-022 SHALL always produce r in range 0..46.

Reset
REQ-023 SHALL, with rst high on any edge, force state=IDLE, acc=0, cnt=0, r=0, out_valid=0 and in_ready=1 from the next cycle; err=0 also applies when the feature in REQ-025 is built in.
REQ-024 SHALL, on reset during BUSY or DONE, abort the operation silently and produce no result.

Configuration
REQ-025 SHALL, with MOD47_ERR_EN defined, add output port err (1 bit), registered at accept as (a>=47)|(b>=47), valid while out_valid=1 and cleared on return to IDLE.
REQ-026 SHALL, with MOD47_ERR_EN undefined, omit the err port and its flop, and silently reduce out-of-range operands as in REQ-013.

Structure
REQ-027 SHALL define MOD=47, W=6, the 3-state FSM enum and the reduce-once function in a shared package, mod47_pkg.
REQ-028 SHALL implement the combinational Horner step (acc, a', bit -> next acc) as sub-module mod47_step, instantiated once.

Verification
REQ-029 SHALL cover a=5, b=7: r=35 exactly 6 edges after accept.
REQ-030 SHALL cover a=46, b=46: r=1; and a=13, b=29: r=1 (377 mod 47).
REQ-031 SHALL cover a=0, b=46 and a=46, b=0: r=0 after 6 edges.
REQ-032 SHALL cover a=50, b=2: r=6; with MOD47_ERR_EN, err=1; a=3, b=2 gives err=0.
REQ-033 SHALL cover out_ready held low 10 cycles in DONE: r and out_valid stable, in_ready=0 and in_valid pulses ignored; on release, IDLE follows next cycle.
REQ-034 SHALL cover rst asserted on the 3rd BUSY cycle: out_valid=0, r=0 and in_ready=1 the next cycle; a fresh 5*7 then yields 35.
